// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq -- sequential shift-add multiplier, signed or unsigned operands.
//
// One pair of WIDTH-bit operands is accepted in IDLE. The operands are
// converted to magnitudes, multiplied over STEPS = WIDTH/BITS_PER_CYCLE CALC
// cycles, and in FIX the product sign is applied. The registered product is
// then held in DONE until the consumer takes it.
// The result is valid STEPS+1 rising edges after the accepting edge.
//
// Optional feature: define MULT_SEQ_OVF_EN to add the out_ovf output. out_ovf
// flags a product that does not fit in WIDTH bits, in the selected mode.
//
// WIDTH must be even and at least 8. BITS_PER_CYCLE must divide WIDTH.
// -----------------------------------------------------------------------------
module mult_seq #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y
`ifdef MULT_SEQ_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int PP_W  = WIDTH + BITS_PER_CYCLE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Two's-complement negation at operand width.
    // The most negative value maps onto itself, and as an unsigned
    // magnitude that is exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation at product width
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude times a BITS_PER_CYCLE-bit slice of the multiplier.
    // The result is formed as a sum of shifted copies of the magnitude.
    function automatic logic [PP_W-1:0] partial_product(
        input logic [WIDTH-1:0]          a,
        input logic [BITS_PER_CYCLE-1:0] bits
    );
        logic [PP_W-1:0] pp;
        pp = {PP_W{1'b0}};
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (bits[j]) begin
                pp = pp + ({{BITS_PER_CYCLE{1'b0}}, a} << j);
            end else begin
                pp = pp;
            end
        end
        return pp;
    endfunction

`ifdef MULT_SEQ_OVF_EN
    // Product does not fit in WIDTH bits.
    // Signed: the sign bit and all bits above it must agree.
    // Unsigned: the upper half must be zero.
    function automatic logic overflow(
        input logic [2*WIDTH-1:0] y,
        input logic               is_signed
    );
        logic [WIDTH:0]   top_s;
        logic [WIDTH-1:0] top_u;
        logic             ovf;
        top_s = y[2*WIDTH-1:WIDTH-1];
        top_u = y[2*WIDTH-1:WIDTH];
        if (is_signed) begin
            ovf = (top_s != {(WIDTH+1){1'b0}}) && (top_s != {(WIDTH+1){1'b1}});
        end else begin
            ovf = (top_u != {WIDTH{1'b0}});
        end
        return ovf;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]           state_r;
    logic [1:0]           state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     mag_a_r;
    // Upper half: running sum. Lower half: multiplier bits not yet consumed,
    // shifted out at the bottom as result bits shift in from the top.
    logic [2*WIDTH-1:0]   acc_r;
    logic                 neg_r;
`ifdef MULT_SEQ_OVF_EN
    logic                 signed_r;
    logic                 ovf_s;
`endif

    logic                 accept_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [PP_W-1:0]      sum_s;
    logic [2*WIDTH-1:0]   acc_step_s;
    logic [2*WIDTH-1:0]   fixed_s;

    // Input handshake and operand magnitudes at the point of acceptance
    always_comb begin
        accept_s = in_valid && (state_r == IDLE);
        a_neg_s  = in_signed & in_a[WIDTH-1];
        b_neg_s  = in_signed & in_b[WIDTH-1];
        if (a_neg_s) begin
            mag_a_s = neg_w(in_a);
        end else begin
            mag_a_s = in_a;
        end
        if (b_neg_s) begin
            mag_b_s = neg_w(in_b);
        end else begin
            mag_b_s = in_b;
        end
    end

    // Next-state logic. A reset overrides every transition here.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = CALC;
                end
            end
            FIX: begin
                state_next_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One shift-add step: add partial product to the upper half of acc_r
    always_comb begin
        sum_s = {{BITS_PER_CYCLE{1'b0}}, acc_r[2*WIDTH-1:WIDTH]}
              + partial_product(mag_a_r, acc_r[BITS_PER_CYCLE-1:0]);
    end

    // Retire the consumed multiplier bits by shifting the accumulator right.
    // This is split by case because a single step per operand has no bits
    // left to keep.
    generate
        if (BITS_PER_CYCLE < WIDTH) begin : g_shift
            always_comb begin
                acc_step_s = {sum_s, acc_r[WIDTH-1:BITS_PER_CYCLE]};
            end
        end else begin : g_single
            always_comb begin
                acc_step_s = sum_s;
            end
        end
    endgenerate

    // Apply the product sign. Zero is never negated.
    always_comb begin
        if (neg_r && (acc_r != {(2*WIDTH){1'b0}})) begin
            fixed_s = neg_2w(acc_r);
        end else begin
            fixed_s = acc_r;
        end
    end

`ifdef MULT_SEQ_OVF_EN
    // Representability of the signed or unsigned final product
    always_comb begin
        ovf_s = overflow(fixed_s, signed_r);
    end
`endif

    // Control path: FSM state, step counter, registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            in_ready  <= (state_next_s == IDLE);
            out_valid <= (state_next_s == DONE);
            if (accept_s) begin
                cnt_r <= CNT_LOAD;
            end else if (state_r == CALC) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Datapath: capture operands on accept, one shift-add step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a_r  <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            neg_r    <= 1'b0;
`ifdef MULT_SEQ_OVF_EN
            signed_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mag_a_r  <= mag_a_s;
                        acc_r    <= {{WIDTH{1'b0}}, mag_b_s};
                        neg_r    <= a_neg_s ^ b_neg_s;
`ifdef MULT_SEQ_OVF_EN
                        signed_r <= in_signed;
`endif
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Result register. It is loaded only in FIX and otherwise keeps the
    // last product.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_y   <= {(2*WIDTH){1'b0}};
`ifdef MULT_SEQ_OVF_EN
            out_ovf <= 1'b0;
`endif
        end else if (state_r == FIX) begin
            out_y   <= fixed_s;
`ifdef MULT_SEQ_OVF_EN
            out_ovf <= ovf_s;
`endif
        end else begin
            out_y   <= out_y;
`ifdef MULT_SEQ_OVF_EN
            out_ovf <= out_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_seq -- directed checks of mult_seq.
// The main instance is WIDTH=64/BPC=1. A second instance, WIDTH=32/BPC=4,
// is run against an arithmetic reference. Overflow checks are compiled in
// when MULT_SEQ_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 64/1 instance
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_a;
    logic [63:0]   in_b;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_y;
    logic          out_ovf;

    // 32/4 instance
    logic          s_rst;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [31:0]   s_in_a;
    logic [31:0]   s_in_b;
    logic          s_in_signed;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [63:0]   s_out_y;
    logic          s_out_ovf;

`ifndef MULT_SEQ_OVF_EN
    assign out_ovf   = 1'b0;
    assign s_out_ovf = 1'b0;
`endif

    mult_seq #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
`ifdef MULT_SEQ_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut32 (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_signed(s_in_signed),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_y(s_out_y)
`ifdef MULT_SEQ_OVF_EN
        , .out_ovf(s_out_ovf)
`endif
    );

    // Drive one transaction on the 64-bit instance.
    // Returns the result and the edges from accept to out_valid
    // (200 means the wait timed out).
    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output logic [127:0] y, output logic ovf, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        y = out_y;
        ovf = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Drive one transaction on the 32-bit instance
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] y, output logic ovf, output int lat);
        int guard;
        guard = 0;
        while (!s_in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        s_in_a = a; s_in_b = b; s_in_signed = s; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        y = s_out_y;
        ovf = s_out_ovf;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        in_valid = 1'b1; in_a = 64'd5; in_b = 64'd5; in_signed = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = 32'd0; s_in_b = 32'd0; s_in_signed = 1'b0; s_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_y !== 128'd0) begin n_fail++; $display("FAIL reset_out_y: got %h want 0", out_y); end
`ifdef MULT_SEQ_OVF_EN
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
`endif
        rst = 1'b0; s_rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_priority_no_accept: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [127:0] y; logic ovf; int lat;
        op64(64'd4, 64'd6, 1'b1, y, ovf, lat);
        n_checks++; if (y !== 128'd24) begin n_fail++; $display("FAIL basic_4x6: got %h want 24", y); end
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL basic_latency: got %0d want 65", lat); end
`ifdef MULT_SEQ_OVF_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", ovf); end
`endif
    endtask

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic         s;
        logic [127:0] y;
        logic         ovf;
    } vec_t;

    task automatic test_corners();
        vec_t tbl[10];
        logic [127:0] y; logic ovf; int lat;
        tbl[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 128'hC000_0000_0000_0000_8000_0000_0000_0000, 1'b1};
        tbl[1] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1};
        tbl[2] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd0, 1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, 1'b0};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 1'b0};
        tbl[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 1'b1};
        tbl[7] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0, 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b1};
        tbl[8] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 1'b1};
        tbl[9] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 1'b0};
        for (int i = 0; i < 10; i++) begin
            op64(tbl[i].a, tbl[i].b, tbl[i].s, y, ovf, lat);
            n_checks++; if (y !== tbl[i].y) begin n_fail++; $display("FAIL corner%0d_y: got %h want %h", i, y, tbl[i].y); end
            n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL corner%0d_latency: got %0d want 65", i, lat); end
`ifdef MULT_SEQ_OVF_EN
            n_checks++; if (ovf !== tbl[i].ovf) begin n_fail++; $display("FAIL corner%0d_ovf: got %b want %b", i, ovf, tbl[i].ovf); end
`endif
        end
    endtask

    task automatic test_backpressure();
        int lat;
        in_a = 64'd12345; in_b = 64'd1000; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL bp_latency: got %0d want 65", lat); end
        n_checks++; if (out_y !== 128'h0000_0000_0000_0000_0000_0000_00BC_5EA8) begin n_fail++; $display("FAIL bp_y: got %h want bc5ea8", out_y); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_a = 64'd77 + 64'(i); in_b = 64'd3; in_signed = 1'b1;
            @(posedge clk); #1;
            n_checks++; if (out_y !== 128'h0000_0000_0000_0000_0000_0000_00BC_5EA8) begin n_fail++; $display("FAIL bp_hold_y cycle %0d: got %h want bc5ea8", i, out_y); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cycle %0d: got %b want 1", i, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready cycle %0d: got %b want 0", i, in_ready); end
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_y !== 128'h0000_0000_0000_0000_0000_0000_00BC_5EA8) begin n_fail++; $display("FAIL bp_idle_keeps_y: got %h want bc5ea8", out_y); end
    endtask

    task automatic test_reset_abort();
        logic [127:0] y; logic ovf; int lat; logic seen;
        in_a = 64'd7; in_b = 64'd9; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_y !== 128'd0) begin n_fail++; $display("FAIL abort_out_y: got %h want 0", out_y); end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: out_valid seen %b want 0", seen); end
        op64(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, y, ovf, lat);
        n_checks++; if (y !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL abort_next_3x-5: got %h want -15", y); end
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 65", lat); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] y; logic ovf; int lat;
        op64(64'd100, 64'd200, 1'b0, y, ovf, lat);
        n_checks++; if (y !== 128'd20000) begin n_fail++; $display("FAIL b2b_first: got %h want 4e20", y); end
        in_a = 64'hFFFF_FFFF_FFFF_FFF9; in_b = 64'd8; in_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_y !== 128'd20000) begin n_fail++; $display("FAIL b2b_keep_last: got %h want 4e20", out_y); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accepted: in_ready got %b want 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++; if (out_y !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC8) begin n_fail++; $display("FAIL b2b_second: got %h want -56", out_y); end
        n_checks++; if (lat !== 65) begin n_fail++; $display("FAIL b2b_latency: got %0d want 65", lat); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random32();
        logic [31:0] a, b; logic s;
        logic [63:0] y, exp_y; logic ovf, exp_ovf; int lat;
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i < 4) begin
                a = (i[0] == 1'b1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                b = (i[1] == 1'b1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
            ua = {32'd0, a};       ub = {32'd0, b};
            if (s) begin
                exp_y = sa * sb;
                exp_ovf = (exp_y[63:31] != 33'd0) && (exp_y[63:31] != {33{1'b1}});
            end else begin
                exp_y = ua * ub;
                exp_ovf = (exp_y[63:32] != 32'd0);
            end
            op32(a, b, s, y, ovf, lat);
            n_checks++; if (y !== exp_y) begin n_fail++; $display("FAIL rand32_y #%0d a=%h b=%h s=%b: got %h want %h", i, a, b, s, y, exp_y); end
            n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL rand32_latency #%0d: got %0d want 9", i, lat); end
`ifdef MULT_SEQ_OVF_EN
            n_checks++; if (ovf !== exp_ovf) begin n_fail++; $display("FAIL rand32_ovf #%0d: got %b want %b", i, ovf, exp_ovf); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
